// File: rtl/uart_frame_parser.sv
`default_nettype none
// ============================================================================
//  Module   : uart_frame_parser
//  Purpose  : Finds HEAD0,HEAD1,LEN,payload,CSUM frames in a UART byte stream,
//             buffers the payload and releases it on a valid/ready stream only
//             once the additive checksum (LEN + payload, mod 256) matches.
//  Ports    : i_clk_sys/i_rst        clock, asynchronous active-high reset
//             i_rx_data/i_rx_done    received byte + one-cycle strobe
//             o_pkt_data/valid/last  payload stream, i_pkt_ready backpressure
//             o_pkt_len              LEN of the most recent good frame
//             o_busy                 parser not in IDLE
//             o_csum_err/o_len_err/o_timeout_err/o_drop  one-cycle pulses
//  Revision : 1.0  initial release
// ============================================================================
module uart_frame_parser #(
    parameter int          CLK_FRE    = 50,
    parameter int          TIMEOUT_US = 2000,
    parameter int          MAX_LEN    = 64,
    parameter logic [7:0]  HEAD0      = 8'h55,
    parameter logic [7:0]  HEAD1      = 8'hAA
) (
    input  logic       i_clk_sys,
    input  logic       i_rst,
    input  logic [7:0] i_rx_data,
    input  logic       i_rx_done,
    output logic [7:0] o_pkt_data,
    output logic       o_pkt_valid,
    input  logic       i_pkt_ready,
    output logic       o_pkt_last,
    output logic [7:0] o_pkt_len,
    output logic       o_busy,
    output logic       o_csum_err,
    output logic       o_len_err,
    output logic       o_timeout_err,
    output logic       o_drop
);

    localparam int              c_TICKS = CLK_FRE * TIMEOUT_US;
    localparam int              c_TW    = $clog2(c_TICKS + 1);
    localparam int              c_AW    = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam logic [c_TW-1:0] c_TLIM  = c_TW'(c_TICKS - 1);
    localparam logic [7:0]      c_MAX   = 8'(MAX_LEN);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_HDR1    = 3'd1,
        S_LEN     = 3'd2,
        S_PAYLOAD = 3'd3,
        S_CSUM    = 3'd4,
        S_OUTPUT  = 3'd5
    } state_t;

    state_t          state_q, state_d;
    logic [7:0]      len_q, len_d;
    logic [7:0]      idx_q, idx_d;
    logic [7:0]      sum_q, sum_d;
    logic [7:0]      rd_q, rd_d;
    logic [c_TW-1:0] tcnt_q, tcnt_d;
    logic            pkt_valid_q, pkt_valid_d;
    logic            pkt_last_q, pkt_last_d;
    logic [7:0]      pkt_len_q, pkt_len_d;
    logic            busy_q, busy_d;
    logic            csum_err_q, csum_err_d;
    logic            len_err_q, len_err_d;
    logic            timeout_err_q, timeout_err_d;
    logic            drop_q, drop_d;
    logic [7:0]      pkt_data_q;

    logic            w_we;
    logic            w_load;
    logic            w_timeout;
    logic [c_AW-1:0] w_waddr;
    logic [c_AW-1:0] w_raddr;

    logic [7:0]      mem [0:MAX_LEN-1];

    always_comb begin
        state_d       = state_q;
        len_d         = len_q;
        idx_d         = idx_q;
        sum_d         = sum_q;
        rd_d          = rd_q;
        pkt_valid_d   = pkt_valid_q;
        pkt_last_d    = pkt_last_q;
        pkt_len_d     = pkt_len_q;
        csum_err_d    = 1'b0;
        len_err_d     = 1'b0;
        timeout_err_d = 1'b0;
        drop_d        = 1'b0;
        w_we          = 1'b0;
        w_load        = 1'b0;
        w_waddr       = idx_q[c_AW-1:0];
        w_raddr       = rd_q[c_AW-1:0];

        // Gap timer only runs while a frame is being collected; any byte
        // restarts it, and a byte arriving on the terminal count wins.
        if (i_rx_done || state_q == S_IDLE || state_q == S_OUTPUT) begin
            tcnt_d = '0;
        end else begin
            tcnt_d = tcnt_q + c_TW'(1);
        end
        w_timeout = !i_rx_done && (tcnt_q == c_TLIM) &&
                    (state_q inside {S_HDR1, S_LEN, S_PAYLOAD, S_CSUM});

        case (state_q)
            S_IDLE: begin
                if (i_rx_done && i_rx_data == HEAD0) state_d = S_HDR1;
            end
            S_HDR1: begin
                if (i_rx_done) begin
                    if (i_rx_data == HEAD1)      state_d = S_LEN;
                    else if (i_rx_data == HEAD0) state_d = S_HDR1;
                    else                         state_d = S_IDLE;
                end
            end
            S_LEN: begin
                if (i_rx_done) begin
                    if (i_rx_data == 8'd0 || i_rx_data > c_MAX) begin
                        len_err_d = 1'b1;
                        state_d   = S_IDLE;
                    end else begin
                        len_d   = i_rx_data;
                        sum_d   = i_rx_data;
                        idx_d   = 8'd0;
                        state_d = S_PAYLOAD;
                    end
                end
            end
            S_PAYLOAD: begin
                if (i_rx_done) begin
                    w_we  = 1'b1;
                    idx_d = idx_q + 8'd1;
                    sum_d = sum_q + i_rx_data;
                    if (idx_q + 8'd1 == len_q) state_d = S_CSUM;
                end
            end
            S_CSUM: begin
                if (i_rx_done) begin
                    if (i_rx_data == sum_q) begin
                        pkt_len_d = len_q;
                        rd_d      = 8'd0;
                        state_d   = S_OUTPUT;
                    end else begin
                        csum_err_d = 1'b1;
                        state_d    = S_IDLE;
                    end
                end
            end
            S_OUTPUT: begin
                drop_d = i_rx_done;
                if (pkt_valid_q && i_pkt_ready && pkt_last_q) begin
                    pkt_valid_d = 1'b0;
                    pkt_last_d  = 1'b0;
                    state_d     = S_IDLE;
                end else if ((!pkt_valid_q || i_pkt_ready) && rd_q != len_q) begin
                    // Fetch the next byte whenever the output register is
                    // empty or being drained this cycle: no bubbles.
                    w_load      = 1'b1;
                    pkt_valid_d = 1'b1;
                    pkt_last_d  = (rd_q == len_q - 8'd1);
                    rd_d        = rd_q + 8'd1;
                end else if (pkt_valid_q && i_pkt_ready) begin
                    pkt_valid_d = 1'b0;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (w_timeout) begin
            timeout_err_d = 1'b1;
            state_d       = S_IDLE;
        end

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge i_clk_sys or posedge i_rst) begin
        if (i_rst) begin
            state_q       <= S_IDLE;
            len_q         <= 8'd0;
            idx_q         <= 8'd0;
            sum_q         <= 8'd0;
            rd_q          <= 8'd0;
            tcnt_q        <= '0;
            pkt_valid_q   <= 1'b0;
            pkt_last_q    <= 1'b0;
            pkt_len_q     <= 8'd0;
            busy_q        <= 1'b0;
            csum_err_q    <= 1'b0;
            len_err_q     <= 1'b0;
            timeout_err_q <= 1'b0;
            drop_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            len_q         <= len_d;
            idx_q         <= idx_d;
            sum_q         <= sum_d;
            rd_q          <= rd_d;
            tcnt_q        <= tcnt_d;
            pkt_valid_q   <= pkt_valid_d;
            pkt_last_q    <= pkt_last_d;
            pkt_len_q     <= pkt_len_d;
            busy_q        <= busy_d;
            csum_err_q    <= csum_err_d;
            len_err_q     <= len_err_d;
            timeout_err_q <= timeout_err_d;
            drop_q        <= drop_d;
        end
    end

    // Payload buffer: plain write port, no reset on the array.
    always_ff @(posedge i_clk_sys) begin
        if (w_we) mem[w_waddr] <= i_rx_data;
    end

    // Synchronous read port; its register doubles as the stream data output.
    always_ff @(posedge i_clk_sys or posedge i_rst) begin
        if (i_rst) begin
            pkt_data_q <= 8'd0;
        end else if (w_load) begin
            pkt_data_q <= mem[w_raddr];
        end
    end

    assign o_pkt_data    = pkt_data_q;
    assign o_pkt_valid   = pkt_valid_q;
    assign o_pkt_last    = pkt_last_q;
    assign o_pkt_len     = pkt_len_q;
    assign o_busy        = busy_q;
    assign o_csum_err    = csum_err_q;
    assign o_len_err     = len_err_q;
    assign o_timeout_err = timeout_err_q;
    assign o_drop        = drop_q;

endmodule
`default_nettype wire

// File: doc/uart_frame_parser.md
# uart_frame_parser

Downstream consumer of the UART byte receiver. Takes received bytes with a one-cycle done strobe, finds frames of the form HEAD0, HEAD1, LEN, LEN payload bytes, CSUM, and buffers the payload. It releases the payload on a valid/ready stream only after the checksum matches, and reports length, checksum and inter-byte timeout errors as single-cycle pulses.

## Interface
Parameters:
- CLK_FRE, 50, system clock in MHz
- TIMEOUT_US, 2000, maximum gap between bytes inside a frame, in µs
- MAX_LEN, 64, maximum payload length in bytes (1..255)
- HEAD0, 8'h55, first header byte
- HEAD1, 8'hAA, second header byte

Ports (one clock; reset is asynchronous and active-high):
- i_clk_sys  in  1  system clock
- i_rst  in  1  asynchronous reset, active-high
- i_rx_data  in  8  received byte; valid only when i_rx_done=1
- i_rx_done  in  1  one-cycle strobe, one per received byte
- o_pkt_data  out  8  payload byte
- o_pkt_valid  out  1  o_pkt_data is valid
- i_pkt_ready  in  1  sink accepts the current byte
- o_pkt_last  out  1  high with the final payload byte
- o_pkt_len  out  8  LEN of the frame being output; held until the next good frame
- o_busy  out  1  high in every state except IDLE
- o_csum_err  out  1  pulse: checksum mismatch
- o_len_err  out  1  pulse: LEN=0 or LEN>MAX_LEN
- o_timeout_err  out  1  pulse: inter-byte timeout
- o_drop  out  1  pulse: a byte arrived during OUTPUT and was discarded

## Operation
- States: IDLE, HDR1, LEN, PAYLOAD, CSUM, OUTPUT. Transitions occur only on i_rx_done, except timeout and the OUTPUT exits.
- IDLE: byte==HEAD0 → HDR1. Any other byte is ignored.
- HDR1: byte==HEAD1 → LEN. Byte==HEAD0 → stay in HDR1. Any other byte → IDLE.
- LEN: LEN=0 or LEN>MAX_LEN → pulse o_len_err, → IDLE. Otherwise latch len, set sum=LEN, idx=0, → PAYLOAD.
- PAYLOAD: write the byte to buffer[idx], idx+=1, sum+=byte (8-bit, wraps mod 256). When idx reaches len → CSUM.
- CSUM: byte==sum → OUTPUT, load o_pkt_len=len, rd=0. Mismatch → pulse o_csum_err, → IDLE, buffer discarded.
- OUTPUT:
  - Stream buffer[0..len-1]; o_pkt_last=1 exactly on index len-1.
  - After the last byte is transferred (valid&ready) → IDLE.
  - Every i_rx_done in OUTPUT pulses o_drop; the byte is ignored and does not start header search.
- Buffer: MAX_LEN×8 synchronous-read RAM with one write port and one read port.
- Timeout:
  - Counter width is ceil(log2(CLK_FRE*TIMEOUT_US+1)).
  - The counter clears on every i_rx_done and in IDLE/OUTPUT.
  - In HDR1/LEN/PAYLOAD/CSUM, reaching CLK_FRE*TIMEOUT_US-1 pulses o_timeout_err and forces IDLE.
  - If timeout and i_rx_done coincide, i_rx_done wins: the byte is processed and the counter clears.
- Error pulses are exactly one cycle wide and mutually exclusive per cycle.

## Timing
- Reset values:
  - o_pkt_data=0, o_pkt_valid=0, o_pkt_last=0, o_pkt_len=0, o_busy=0
  - all error pulses 0, state IDLE, counters 0
- Reset mid-frame or mid-OUTPUT aborts immediately. No error pulse is generated.
- State updates on the clock edge where i_rx_done=1. o_busy reflects the new state one cycle later.
- Output latency:
  - CSUM strobe at cycle T → state OUTPUT at T+1.
  - o_pkt_valid first high at T+2, with o_pkt_data=buffer[0].
- Stream rules:
  - With ready held high, one byte is transferred per cycle; no bubbles between bytes.
  - While valid&!ready, o_pkt_data and o_pkt_last hold stable and valid stays high.
  - valid never drops before the transfer completes.
- Last byte: o_pkt_valid deasserts the cycle after the last transfer. The next header byte is accepted in the first cycle of IDLE.
- Errors: an error pulse asserts the cycle after the offending i_rx_done, or the cycle after the count terminates for timeout.

## Test plan
- Good frame 55 AA 03 11 22 33 69 with ready=1 → bytes 11, 22, 33 with last on 33; o_pkt_len=3; no error pulses; valid first high 2 cycles after the CSUM strobe.
- Same frame with CSUM=68 → one o_csum_err pulse; o_pkt_valid never rises; the next good frame parses correctly.
- LEN=00, and separately LEN=MAX_LEN+1 → o_len_err pulse each time; return to IDLE.
- Resync: 55 55 AA 01 7F 80 → one output byte 7F. Noise bytes 00 FF before 55 are ignored.
- Stall: ready toggles 1,0,0,1 during a 4-byte payload → no byte lost or duplicated; data stable while stalled. A byte strobed during OUTPUT → o_drop pulse, stream unaffected.
- Timeout with TIMEOUT_US=1, CLK_FRE=50: 55 AA 02 11, then silence → o_timeout_err after 50 cycles; reset asserted mid-PAYLOAD → all outputs at reset values with no error pulse.
